// File: rtl/rf_bypass_pkg.sv
// Shared register-file constants and the register-index type used by
// decode and writeback.
package rf_bypass_pkg;

  localparam int RF_WIDTH = 16;
  localparam int RF_NREG  = 8;
  localparam int RF_AW    = 3;

  typedef logic [RF_AW-1:0] regIdx_t;

endpackage

// File: rtl/rf_reg.sv
// One storage word of the register file: async active-low clear, loads
// i_writeData on a rising clk edge when i_writeEn is high.
module rf_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_writeEn,
  input  logic [WIDTH-1:0] i_writeData,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Clear immediately on reset, otherwise load only when this word is selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_writeEn) begin
      r_q <= i_writeData;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/rf_bypass.sv
// Architectural register file feeding ALU operands A/B. Two combinational
// read ports with same-cycle write-to-read bypass, one synchronous write
// port, and a sticky simulation-only error flag for X/Z accesses.
module rf_bypass
  import rf_bypass_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int NREG  = RF_NREG,
  parameter int AW    = RF_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    read1RegSel,
  input  logic [AW-1:0]    read2RegSel,
  input  logic [AW-1:0]    writeRegSel,
  input  logic [WIDTH-1:0] writeData,
  input  logic             writeEn,
  output logic [WIDTH-1:0] read1Data,
  output logic [WIDTH-1:0] read2Data,
  output logic             err
);

  logic [WIDTH-1:0] w_regQ [NREG];
  logic [NREG-1:0]  w_wrSel;
  logic             w_hit1;
  logic             w_hit2;
  logic             w_errCond;
  logic             r_err;

  // One word per register; the write decoder gates writeEn with a one-hot
  // decode of writeRegSel so exactly one word loads per write.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      assign w_wrSel[gi] = writeEn && (writeRegSel == AW'(gi));

      rf_reg #(.WIDTH(WIDTH)) u_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_writeEn   (w_wrSel[gi]),
        .i_writeData (writeData),
        .o_q         (w_regQ[gi])
      );
    end
  endgenerate

  assign w_hit1 = writeEn && (writeRegSel == read1RegSel);
  assign w_hit2 = writeEn && (writeRegSel == read2RegSel);

  // Port 1 mux: forward the in-flight write on a match, read 0 while in reset.
  always_comb begin
    read1Data = '0;
    if (rst_n) begin
      read1Data = w_hit1 ? writeData : w_regQ[read1RegSel];
    end
  end

  // Port 2 mux: same bypass rule, independent of port 1.
  always_comb begin
    read2Data = '0;
    if (rst_n) begin
      read2Data = w_hit2 ? writeData : w_regQ[read2RegSel];
    end
  end

`ifndef SYNTHESIS
  assign w_errCond = $isunknown(writeEn)
                  || ((writeEn === 1'b1) && $isunknown(writeRegSel))
                  || $isunknown(read1RegSel)
                  || $isunknown(read2RegSel);
`else
  assign w_errCond = 1'b0;
`endif

  // Sticky error flag: once set it holds until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_errCond) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_rf_bypass.sv
// Scoreboard bench for rf_bypass: stimulus pushes expected read/err values
// computed from a plain array model; a monitor pops and compares them.
module tb_rf_bypass;
  import rf_bypass_pkg::*;

  typedef struct {
    string       name;
    logic [15:0] exp1;
    logic [15:0] exp2;
    logic        expErr;
    bit          chkData;
  } exp_t;

  logic        clk;
  logic        rst_n;
  regIdx_t     read1RegSel;
  regIdx_t     read2RegSel;
  regIdx_t     writeRegSel;
  logic [15:0] writeData;
  logic        writeEn;
  logic [15:0] read1Data;
  logic [15:0] read2Data;
  logic        err;

  logic [15:0] model [RF_NREG];
  logic        expErr;
  exp_t        scoreQ [$];
  event        sampleReq;
  int          passCount;
  int          totalCount;

  rf_bypass dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .read1RegSel (read1RegSel),
    .read2RegSel (read2RegSel),
    .writeRegSel (writeRegSel),
    .writeData   (writeData),
    .writeEn     (writeEn),
    .read1Data   (read1Data),
    .read2Data   (read2Data),
    .err         (err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference read: 0 in reset, the write data when it targets this
  // register this cycle, otherwise the stored model value.
  function automatic logic [15:0] expRead(input regIdx_t sel);
    if (!rst_n) return 16'h0000;
    if (writeEn === 1'b1 && writeRegSel == sel) return writeData;
    return model[sel];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < RF_NREG; i++) model[i] = 16'h0000;
  endtask

  task automatic checkOutput(input string nm, input logic [15:0] act, input logic [15:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Record what the DUT should show right now and ask the monitor to check.
  task automatic pushSample(input string nm, input bit chkData);
    exp_t e;
    e.name    = nm;
    e.exp1    = expRead(read1RegSel);
    e.exp2    = expRead(read2RegSel);
    e.expErr  = expErr;
    e.chkData = chkData;
    scoreQ.push_back(e);
    ->sampleReq;
  endtask

  // Drive one cycle (entered just after a rising edge), sample mid-cycle,
  // then commit the write to the model at the next edge.
  task automatic applyStimulus(input string nm, input logic we, input regIdx_t wsel,
                               input logic [15:0] wd, input regIdx_t r1, input regIdx_t r2);
    writeEn     = we;
    writeRegSel = wsel;
    writeData   = wd;
    read1RegSel = r1;
    read2RegSel = r2;
    #2;
    pushSample(nm, 1'b1);
    @(posedge clk);
    if (rst_n && we === 1'b1) model[wsel] = wd;
    #1;
  endtask

  // Monitor: pop one expectation per sample request and compare.
  initial begin
    exp_t e;
    forever begin
      @(sampleReq);
      if (scoreQ.size() == 0) begin
        totalCount++;
        $display("[TB] FAIL scoreboard: sample with no expectation queued");
      end else begin
        e = scoreQ.pop_front();
        if (e.chkData) begin
          checkOutput({e.name, ".read1"}, read1Data, e.exp1);
          checkOutput({e.name, ".read2"}, read2Data, e.exp2);
        end
        checkOutput({e.name, ".err"}, {15'd0, err}, {15'd0, e.expErr});
      end
    end
  end

  // Watchdog so the bench always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic probe;
    passCount  = 0;
    totalCount = 0;
    expErr     = 1'b0;
    clearModel();
    rst_n       = 1'b0;
    writeEn     = 1'b0;
    writeRegSel = '0;
    writeData   = '0;
    read1RegSel = 3'd1;
    read2RegSel = 3'd7;

    // Reset state
    #3;
    pushSample("resetState", 1'b1);
    #9 rst_n = 1'b1;   // t=12, between edges

    // Basic write/read
    applyStimulus("wrR3", 1'b1, 3'd3, 16'h1234, 3'd0, 3'd1);
    applyStimulus("wrR5", 1'b1, 3'd5, 16'hABCD, 3'd3, 3'd4);
    applyStimulus("rdR3R5", 1'b0, 3'd0, 16'h0000, 3'd3, 3'd5);
    for (int i = 0; i < RF_NREG; i += 2)
      applyStimulus("rdAll", 1'b0, 3'd0, 16'h0000, regIdx_t'(i), regIdx_t'(i + 1));

    // Bypass on both ports, then storage after the edge
    applyStimulus("wrR2", 1'b1, 3'd2, 16'h0001, 3'd2, 3'd0);
    applyStimulus("bypassBoth", 1'b1, 3'd2, 16'h00FF, 3'd2, 3'd2);
    applyStimulus("afterBypass", 1'b0, 3'd2, 16'h0000, 3'd2, 3'd2);

    // No false bypass when writeEn is low
    applyStimulus("wrR4", 1'b1, 3'd4, 16'h0007, 3'd0, 3'd0);
    applyStimulus("noFalseBypass", 1'b0, 3'd4, 16'hDEAD, 3'd4, 3'd4);
    applyStimulus("r4Held", 1'b0, 3'd0, 16'h0000, 3'd4, 3'd2);

    // Back-to-back writes to one register: last edge wins
    applyStimulus("b2bA", 1'b1, 3'd0, 16'h1111, 3'd1, 3'd1);
    applyStimulus("b2bB", 1'b1, 3'd0, 16'h2222, 3'd1, 3'd1);
    applyStimulus("b2bRead", 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);

    // Randomized traffic
    for (int i = 0; i < 300; i++)
      applyStimulus("random", 1'($urandom), regIdx_t'($urandom), 16'($urandom),
                    regIdx_t'($urandom), regIdx_t'($urandom));

    // Fill with FFFF, then reset mid-cycle with a write pending
    for (int i = 0; i < RF_NREG; i++)
      applyStimulus("fillFFFF", 1'b1, regIdx_t'(i), 16'hFFFF, regIdx_t'(i), 3'd0);
    writeEn     = 1'b1;
    writeRegSel = 3'd3;
    writeData   = 16'hBEEF;
    read1RegSel = 3'd3;
    read2RegSel = 3'd6;
    #2 rst_n = 1'b0;
    clearModel();
    #1 pushSample("inReset", 1'b1);
    writeEn = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < RF_NREG; i += 2)
      applyStimulus("afterReset", 1'b0, 3'd0, 16'h0000, regIdx_t'(i), regIdx_t'(i + 1));

    // Reset racing a write: rst_n falls 1 ns before the edge
    applyStimulus("preRace", 1'b1, 3'd6, 16'h0042, 3'd6, 3'd6);
    writeEn     = 1'b1;
    writeRegSel = 3'd6;
    writeData   = 16'h5555;
    #8 rst_n = 1'b0;
    clearModel();
    @(posedge clk);
    #2;
    writeEn = 1'b0;
    rst_n   = 1'b1;
    applyStimulus("raceNoReplay", 1'b0, 3'd0, 16'h0000, 3'd6, 3'd6);
    applyStimulus("raceStill0", 1'b0, 3'd0, 16'h0000, 3'd6, 3'd5);

    // Error flag (only observable on a simulator that keeps X values)
    probe = 1'bx;
    if ($isunknown(probe)) begin
      writeEn     = 1'bx;
      writeRegSel = 3'd1;
      writeData   = 16'h0F0F;
      read1RegSel = 3'd0;
      read2RegSel = 3'd2;
      #2 pushSample("errBefore", 1'b0);
      @(posedge clk); #1;
      expErr = 1'b1;
      applyStimulus("errSticky1", 1'b1, 3'd0, 16'h7777, 3'd0, 3'd2);
      applyStimulus("errSticky2", 1'b1, 3'd2, 16'h8888, 3'd0, 3'd2);
      rst_n = 1'b0;
      clearModel();
      expErr = 1'b0;
      #1 pushSample("errCleared", 1'b1);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      applyStimulus("errAfter", 1'b0, 3'd0, 16'h0000, 3'd0, 3'd2);
    end

    #1;
    if (scoreQ.size() != 0) begin
      totalCount++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", scoreQ.size());
    end
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
